// File: rtl/search_module.sv
// search_module
//   Searches for maximal-length feedback tap sets for a SIZE-bit shift register.
//   A 32-bit Galois PRNG proposes tap positions; each complete candidate is
//   then exercised from S=1 and accepted only if S returns to 1 after exactly
//   2^SIZE-1 steps.
//
// Ports
//   clk      in   single clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   launches the search when sampled high in IDLE
//   ext_res  in   host acknowledge; releases a held result in FOUND
//   found    out  a maximal-length tap set is held on co_buf
//   started  out  sticky, set on the edge that leaves IDLE
//   co_buf   out  tap set, tap k in bits [8k+7:8k]
//
// state | meaning
// IDLE  | waiting for start
// GEN   | drawing PRNG bytes into tap slots, one draw per cycle
// TEST  | stepping the candidate register, counting the period
// FOUND | maximal-length candidate held until ext_res

module search_module #(
  parameter int NUM_OF_TAPS = 6,
  parameter int SIZE        = 20,
  parameter int SEED        = 1351
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     ext_res,
  output logic                     found,
  output logic                     started,
  output logic [NUM_OF_TAPS*8-1:0] co_buf
);

  localparam logic [31:0]     PRNG_INIT = (SEED == 0) ? 32'd1 : 32'(SEED);
  localparam logic [31:0]     PRNG_POLY = 32'h8020_0003;
  localparam int              KW        = (NUM_OF_TAPS > 1) ? $clog2(NUM_OF_TAPS) : 1;
  localparam logic [KW-1:0]   K_LAST    = KW'(NUM_OF_TAPS - 1);
  // Counter value on the step that would be the (2^SIZE-1)th.
  localparam logic [SIZE-1:0] C_LAST    = {SIZE{1'b1}} - SIZE'(1);
  localparam logic [SIZE-1:0] S_ONE     = SIZE'(1);

  typedef enum logic [1:0] {IDLE, GEN, TEST, FOUND} state_e;

  state_e          state_q, state_d;
  logic [31:0]     prng_q, prng_d;
  logic [KW-1:0]   k_q, k_d;
  logic [7:0]      slot_q [NUM_OF_TAPS];
  logic [7:0]      slot_d [NUM_OF_TAPS];
  logic [SIZE-1:0] s_q, s_d;
  logic [SIZE-1:0] c_q, c_d;
  logic            found_q, found_d;
  logic            started_q, started_d;

  logic            fb;
  logic [SIZE-1:0] s_next;
  logic [7:0]      pbyte;
  logic            accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prng_q    <= PRNG_INIT;
      k_q       <= '0;
      s_q       <= S_ONE;
      c_q       <= '0;
      found_q   <= 1'b0;
      started_q <= 1'b0;
      for (int i = 0; i < NUM_OF_TAPS; i++) slot_q[i] <= 8'd0;
    end else begin
      state_q   <= state_d;
      prng_q    <= prng_d;
      k_q       <= k_d;
      s_q       <= s_d;
      c_q       <= c_d;
      found_q   <= found_d;
      started_q <= started_d;
      for (int i = 0; i < NUM_OF_TAPS; i++) slot_q[i] <= slot_d[i];
    end
  end

  always_comb begin
    // Tap positions are runtime values; a compare per bit avoids an
    // over-wide dynamic index into s_q.
    fb = s_q[0];
    for (int i = 0; i < NUM_OF_TAPS; i++)
      for (int j = 0; j < SIZE; j++)
        if (slot_q[i] == 8'(j)) fb = fb ^ s_q[j];
    s_next = {fb, s_q[SIZE-1:1]};
    pbyte  = prng_q[7:0];
    accept = (pbyte != 8'd0) && (pbyte <= 8'(SIZE - 1));

    state_d   = state_q;
    prng_d    = prng_q;
    k_d       = k_q;
    s_d       = s_q;
    c_d       = c_q;
    found_d   = found_q;
    started_d = started_q;
    for (int i = 0; i < NUM_OF_TAPS; i++) slot_d[i] = slot_q[i];

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = GEN;
          started_d = 1'b1;
        end
      end
      GEN: begin
        prng_d = {1'b0, prng_q[31:1]} ^ (prng_q[0] ? PRNG_POLY : 32'd0);
        if (accept) begin
          for (int i = 0; i < NUM_OF_TAPS; i++)
            if (k_q == KW'(i)) slot_d[i] = pbyte;
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = TEST;
            s_d     = S_ONE;
            c_d     = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      TEST: begin
        s_d = s_next;
        c_d = c_q + S_ONE;
        if (s_next == S_ONE) begin
          if (c_q == C_LAST) begin
            state_d = FOUND;
            found_d = 1'b1;
          end else begin
            state_d = GEN;
          end
        end else if (c_q == C_LAST) begin
          // Full period elapsed without returning: register is stuck.
          state_d = GEN;
        end
      end
      FOUND: begin
        if (ext_res) begin
          state_d = GEN;
          found_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_OF_TAPS; i++) co_buf[8*i +: 8] = slot_q[i];
  end

  assign found   = found_q;
  assign started = started_q;

endmodule

// File: tb/tb_search_module.sv
module tb_search_module;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_a  [3];
  logic        start_a [3];
  logic        ext_a   [3];
  logic        f0, f1, f2, s0, s1, s2;
  logic [47:0] cb0;
  logic [7:0]  cb1;
  logic [23:0] cb2;

  search_module #(.NUM_OF_TAPS(6), .SIZE(20), .SEED(1351)) u0 (
    .clk(clk), .rst_n(rstn_a[0]), .start(start_a[0]), .ext_res(ext_a[0]),
    .found(f0), .started(s0), .co_buf(cb0));
  search_module #(.NUM_OF_TAPS(1), .SIZE(4), .SEED(1351)) u1 (
    .clk(clk), .rst_n(rstn_a[1]), .start(start_a[1]), .ext_res(ext_a[1]),
    .found(f1), .started(s1), .co_buf(cb1));
  search_module #(.NUM_OF_TAPS(3), .SIZE(8), .SEED(1351)) u2 (
    .clk(clk), .rst_n(rstn_a[2]), .start(start_a[2]), .ext_res(ext_a[2]),
    .found(f2), .started(s2), .co_buf(cb2));

  logic        found_a   [3];
  logic        started_a [3];
  logic [47:0] cb_a      [3];
  always_comb begin
    found_a[0] = f0; found_a[1] = f1; found_a[2] = f2;
    started_a[0] = s0; started_a[1] = s1; started_a[2] = s2;
    cb_a[0] = cb0;
    cb_a[1] = {40'd0, cb1};
    cb_a[2] = {24'd0, cb2};
  end

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [47:0] taps;
    logic        is_max;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] prng_m [3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] prng_adv(input logic [31:0] p);
    return (p >> 1) ^ (p[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Draws bytes until nt taps are accepted; g = number of GEN cycles used.
  task automatic gen_model(input int i, input int size, input int nt,
                           output logic [47:0] taps, output int g);
    int k;
    logic [7:0] b;
    taps = '0;
    g = 0;
    k = 0;
    while (k < nt) begin
      b = prng_m[i][7:0];
      prng_m[i] = prng_adv(prng_m[i]);
      g++;
      if (int'(b) >= 1 && int'(b) <= size - 1) begin
        taps[8*k +: 8] = b;
        k++;
      end
    end
  endtask

  // Steps from 1 until 1 reappears; 0 means no return within 2^size-1 steps.
  function automatic int period(input logic [47:0] taps, input int size, input int nt);
    logic [255:0] s;
    logic fb;
    s = 256'd1;
    for (int n = 1; n <= (1 << size) - 1; n++) begin
      fb = s[0];
      for (int j = 0; j < nt; j++) fb = fb ^ s[taps[8*j +: 8]];
      s = s >> 1;
      s[size-1] = fb;
      if (s == 256'd1) return n;
    end
    return 0;
  endfunction

  task automatic run_search(input int i, input int size, input int nt,
                            input int want_found, input int max_cand, input bit do_hold);
    int founds, maxp, g, p, t;
    logic [47:0] taps;
    logic prev_ext;
    exp_t e;
    founds = 0;
    maxp = (1 << size) - 1;
    for (int c = 0; c < max_cand && founds < want_found; c++) begin
      gen_model(i, size, nt, taps, g);
      p = period(taps, size, nt);
      e.taps = taps;
      e.is_max = (p == maxp);
      t = (p == 0) ? maxp : p;
      sbq.push_back(e);
      tick(g + t - 1);
      check($sformatf("pre_found_u%0d_c%0d", i, c), 64'(found_a[i]), 64'd0);
      tick(1);
      e = sbq.pop_front();
      check($sformatf("found_u%0d_c%0d", i, c), 64'(found_a[i]), 64'(e.is_max));
      check($sformatf("co_buf_u%0d_c%0d", i, c), 64'(cb_a[i]), 64'(e.taps));
      for (int j = 0; j < nt; j++)
        check($sformatf("tap_range_u%0d_c%0d_t%0d", i, c, j),
              64'(int'(cb_a[i][8*j +: 8]) >= 1 && int'(cb_a[i][8*j +: 8]) <= size - 1), 64'd1);
      if (e.is_max) begin
        founds++;
        if (size == 4)
          check("tap_1_or_3", 64'(cb_a[i][7:0] == 8'd1 || cb_a[i][7:0] == 8'd3), 64'd1);
        if (do_hold && founds == 1) begin
          for (int h = 0; h < 100; h++) begin
            tick(1);
            check("hold_found", 64'(found_a[i]), 64'd1);
          end
          check("hold_co_buf", 64'(cb_a[i]), 64'(e.taps));
        end
        prev_ext = ext_a[i];
        ext_a[i] = 1'b1;
        tick(1);
        ext_a[i] = prev_ext;
        check($sformatf("found_clear_u%0d", i), 64'(found_a[i]), 64'd0);
      end
    end
    check($sformatf("found_count_u%0d", i), 64'(founds >= want_found), 64'd1);
  endtask

  initial begin
    logic [47:0] taps;
    int g;
    for (int i = 0; i < 3; i++) begin
      rstn_a[i]  = 1'b0;
      start_a[i] = 1'b0;
      ext_a[i]   = 1'b0;
      prng_m[i]  = 32'd1351;
    end
    tick(3);
    check("rst_found", 64'(f0), 64'd0);
    check("rst_started", 64'(s0), 64'd0);
    check("rst_co_buf", 64'(cb0), 64'd0);
    for (int i = 0; i < 3; i++) rstn_a[i] = 1'b1;

    // Idle without start, then a single-cycle start.
    tick(50);
    check("idle_started", 64'(s0), 64'd0);
    check("idle_co_buf", 64'(cb0), 64'd0);
    check("idle_found", 64'(f0), 64'd0);
    start_a[0] = 1'b1;
    tick(1);
    start_a[0] = 1'b0;
    check("start_started", 64'(s0), 64'd1);
    gen_model(0, 20, 6, taps, g);
    tick(g - 1);
    check("gen_started_sticky", 64'(s0), 64'd1);
    tick(1);
    check("gen20_co_buf", 64'(cb0), 64'(taps));
    tick(10);
    check("test_started_sticky", 64'(s0), 64'd1);

    // Asynchronous reset in the middle of TEST.
    #3;
    rstn_a[0] = 1'b0;
    #1;
    check("midtest_rst_found", 64'(f0), 64'd0);
    check("midtest_rst_started", 64'(s0), 64'd0);
    check("midtest_rst_co_buf", 64'(cb0), 64'd0);
    tick(2);
    rstn_a[0] = 1'b1;
    tick(20);
    check("post_rst_started", 64'(s0), 64'd0);
    check("post_rst_co_buf", 64'(cb0), 64'd0);

    // SIZE=4, one tap; ext_res held high throughout, so it must be ignored
    // everywhere except FOUND.
    ext_a[1] = 1'b1;
    tick(5);
    check("u1_idle_ext_ignored", 64'(s1), 64'd0);
    start_a[1] = 1'b1;
    tick(1);
    start_a[1] = 1'b0;
    check("u1_started", 64'(s1), 64'd1);
    run_search(1, 4, 1, 1, 20, 1'b0);
    ext_a[1] = 1'b0;

    // SIZE=8, three taps; start held high so it must be ignored after IDLE.
    start_a[2] = 1'b1;
    tick(1);
    check("u2_started", 64'(s2), 64'd1);
    run_search(2, 8, 3, 3, 60, 1'b1);
    start_a[2] = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
